mem_arbiter: RTL and testbench

Arbitrates one shared single-port memory between the pipeline fetch port (read-only) and the data port (read/write) of the 5-stage RISC-V core.
- Issues one memory transaction at a time over a req/ack handshake with variable latency.
- Returns read data and one-cycle completion strobes.
- Produces per-port busy flags that the hazard unit ORs into stall_f and stall_m.
- Fetch starvation is bounded by a consecutive-grant limit.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/mem_arb_perf_cnt.sv | 35 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types, defaults and the arbitration priority rule for mem_arbiter.
package riscv_pkg;

   localparam int unsigned MP_DATA_WIDTH_DEF   = 32;
   localparam int unsigned MP_ADDR_WIDTH_DEF   = 32;
   localparam int unsigned MP_STARVE_LIMIT_DEF = 4;
   localparam int unsigned MP_STARVE_CNT_W     = 4;
   localparam int unsigned MP_PERF_CNT_W       = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_ACT = 2'd1,
      DM_ACT = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_DM   = 2'd2
   } arb_gnt_e;

   // Data wins ties unless fetch has already waited out the starve limit.
   function automatic arb_gnt_e arb_pick(input logic if_req, input logic dm_req,
                                         input logic starved);
      if (dm_req && !(if_req && starved)) return GNT_DM;
      else if (if_req) return GNT_IF;
      else return GNT_NONE;
   endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Wrapping grant and wait-cycle counters for mem_arbiter (built only with MEM_ARB_PERF_EN).
module mem_arb_perf_cnt
   import riscv_pkg::*;
(
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic                     igrant_if,
   input  logic                     igrant_dm,
   input  logic                     iwait,
   output logic [MP_PERF_CNT_W-1:0] ocnt_if_grants,
   output logic [MP_PERF_CNT_W-1:0] ocnt_dm_grants,
   output logic [MP_PERF_CNT_W-1:0] ocnt_wait_cycles
);

   logic [MP_PERF_CNT_W-1:0] cnt_if_q;
   logic [MP_PERF_CNT_W-1:0] cnt_dm_q;
   logic [MP_PERF_CNT_W-1:0] cnt_wait_q;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         cnt_if_q   <= '0;
         cnt_dm_q   <= '0;
         cnt_wait_q <= '0;
      end else begin
         if (igrant_if) cnt_if_q   <= cnt_if_q + MP_PERF_CNT_W'(1);
         if (igrant_dm) cnt_dm_q   <= cnt_dm_q + MP_PERF_CNT_W'(1);
         if (iwait)     cnt_wait_q <= cnt_wait_q + MP_PERF_CNT_W'(1);
      end
   end

   assign ocnt_if_grants   = cnt_if_q;
   assign ocnt_dm_grants   = cnt_dm_q;
   assign ocnt_wait_cycles = cnt_wait_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data port.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned MP_DATA_WIDTH   = MP_DATA_WIDTH_DEF,
   parameter int unsigned MP_ADDR_WIDTH   = MP_ADDR_WIDTH_DEF,
   parameter int unsigned MP_STARVE_LIMIT = MP_STARVE_LIMIT_DEF
) (
   input  logic                       iclk,
   input  logic                       irst_n,
   input  logic                       iif_req,
   input  logic [MP_ADDR_WIDTH-1:0]   iif_addr,
   output logic [MP_DATA_WIDTH-1:0]   oif_rdata,
   output logic                       oif_valid,
   output logic                       oif_busy,
   input  logic                       idm_req,
   input  logic                       idm_we,
   input  logic [MP_DATA_WIDTH/8-1:0] idm_be,
   input  logic [MP_ADDR_WIDTH-1:0]   idm_addr,
   input  logic [MP_DATA_WIDTH-1:0]   idm_wdata,
   output logic [MP_DATA_WIDTH-1:0]   odm_rdata,
   output logic                       odm_valid,
   output logic                       odm_busy,
   output logic                       omem_req,
   output logic                       omem_we,
   output logic [MP_DATA_WIDTH/8-1:0] omem_be,
   output logic [MP_ADDR_WIDTH-1:0]   omem_addr,
   output logic [MP_DATA_WIDTH-1:0]   omem_wdata,
   input  logic [MP_DATA_WIDTH-1:0]   imem_rdata,
   input  logic                       imem_ack,
   output logic [MP_PERF_CNT_W-1:0]   ocnt_if_grants,
   output logic [MP_PERF_CNT_W-1:0]   ocnt_dm_grants,
   output logic [MP_PERF_CNT_W-1:0]   ocnt_wait_cycles
);

   localparam int unsigned BE_W = MP_DATA_WIDTH / 8;
   localparam logic [MP_STARVE_CNT_W-1:0] STARVE_MAX = MP_STARVE_CNT_W'(MP_STARVE_LIMIT);

   arb_state_e                 state_q;
   logic [MP_STARVE_CNT_W-1:0] starve_q, starve_d;
   arb_gnt_e                   gnt_d;
   logic                       ack_act;
   logic                       arb_en;

   logic                       mem_req_q;
   logic                       mem_we_q;
   logic [BE_W-1:0]            mem_be_q;
   logic [MP_ADDR_WIDTH-1:0]   mem_addr_q;
   logic [MP_DATA_WIDTH-1:0]   mem_wdata_q;
   logic [MP_DATA_WIDTH-1:0]   if_rdata_q;
   logic                       if_valid_q;
   logic [MP_DATA_WIDTH-1:0]   dm_rdata_q;
   logic                       dm_valid_q;

   // An ack only counts while a transaction is outstanding; in IDLE it is dropped.
   assign ack_act = imem_ack && (state_q != IDLE);
   assign arb_en  = (state_q == IDLE) || ack_act;

   always_comb begin
      gnt_d    = GNT_NONE;
      starve_d = starve_q;
      if (arb_en) begin
         gnt_d = arb_pick(iif_req, idm_req, starve_q >= STARVE_MAX);
         if (gnt_d == GNT_IF) begin
            starve_d = '0;
         end else if (gnt_d == GNT_DM) begin
            if (!iif_req)                   starve_d = '0;
            else if (starve_q < STARVE_MAX) starve_d = starve_q + MP_STARVE_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_rdata_q  <= '0;
         dm_valid_q  <= 1'b0;
      end else begin
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         starve_q   <= starve_d;

         if (ack_act && (state_q == IF_ACT)) begin
            if_rdata_q <= imem_rdata;
            if_valid_q <= 1'b1;
         end
         // Store completions keep the last load value visible.
         if (ack_act && (state_q == DM_ACT)) begin
            dm_valid_q <= 1'b1;
            if (!mem_we_q) dm_rdata_q <= imem_rdata;
         end

         if (arb_en) begin
            case (gnt_d)
               GNT_IF: begin
                  state_q     <= IF_ACT;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_be_q    <= '1;
                  mem_addr_q  <= iif_addr;
                  mem_wdata_q <= '0;
               end
               GNT_DM: begin
                  state_q     <= DM_ACT;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= idm_we;
                  mem_be_q    <= idm_be;
                  mem_addr_q  <= idm_addr;
                  mem_wdata_q <= idm_wdata;
               end
               default: begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign omem_req   = mem_req_q;
   assign omem_we    = mem_we_q;
   assign omem_be    = mem_be_q;
   assign omem_addr  = mem_addr_q;
   assign omem_wdata = mem_wdata_q;
   assign oif_rdata  = if_rdata_q;
   assign oif_valid  = if_valid_q;
   assign odm_rdata  = dm_rdata_q;
   assign odm_valid  = dm_valid_q;
   assign oif_busy   = iif_req & ~if_valid_q;
   assign odm_busy   = idm_req & ~dm_valid_q;

`ifdef MEM_ARB_PERF_EN
   mem_arb_perf_cnt u_perf (
      .iclk             (iclk),
      .irst_n           (irst_n),
      .igrant_if        (gnt_d == GNT_IF),
      .igrant_dm        (gnt_d == GNT_DM),
      .iwait            (mem_req_q & ~imem_ack),
      .ocnt_if_grants   (ocnt_if_grants),
      .ocnt_dm_grants   (ocnt_dm_grants),
      .ocnt_wait_cycles (ocnt_wait_cycles)
   );
`else
   assign ocnt_if_grants   = '0;
   assign ocnt_dm_grants   = '0;
   assign ocnt_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written reset, simultaneous-request and starvation sequences.
module tb_mem_arbiter;

   logic        iclk = 1'b0;
   logic        irst_n;
   logic        iif_req;
   logic [31:0] iif_addr;
   logic [31:0] oif_rdata;
   logic        oif_valid, oif_busy;
   logic        idm_req, idm_we;
   logic [3:0]  idm_be;
   logic [31:0] idm_addr, idm_wdata;
   logic [31:0] odm_rdata;
   logic        odm_valid, odm_busy;
   logic        omem_req, omem_we;
   logic [3:0]  omem_be;
   logic [31:0] omem_addr, omem_wdata;
   logic [31:0] mem_rdata;
   logic        imem_ack;
   logic [31:0] ocnt_if_grants, ocnt_dm_grants, ocnt_wait_cycles;

   logic        resp_ack = 1'b0;
   logic        stale_ack = 1'b0;
   int          resp_delay = 0;
   int          rcnt = 0;
   int          total = 0;
   int          bad = 0;

   assign imem_ack = resp_ack | stale_ack;

   mem_arbiter dut (
      .iclk (iclk), .irst_n (irst_n),
      .iif_req (iif_req), .iif_addr (iif_addr),
      .oif_rdata (oif_rdata), .oif_valid (oif_valid), .oif_busy (oif_busy),
      .idm_req (idm_req), .idm_we (idm_we), .idm_be (idm_be),
      .idm_addr (idm_addr), .idm_wdata (idm_wdata),
      .odm_rdata (odm_rdata), .odm_valid (odm_valid), .odm_busy (odm_busy),
      .omem_req (omem_req), .omem_we (omem_we), .omem_be (omem_be),
      .omem_addr (omem_addr), .omem_wdata (omem_wdata),
      .imem_rdata (mem_rdata), .imem_ack (imem_ack),
      .ocnt_if_grants (ocnt_if_grants), .ocnt_dm_grants (ocnt_dm_grants),
      .ocnt_wait_cycles (ocnt_wait_cycles)
   );

   always #5 iclk = ~iclk;

   // Memory model: acks in cycle index resp_delay of each transaction.
   initial begin
      forever begin
         @(posedge iclk);
         #1;
         if (!irst_n || !omem_req) begin
            resp_ack = 1'b0;
            rcnt     = 0;
         end else begin
            if (resp_ack) rcnt = 0;
            resp_ack = (rcnt == resp_delay);
            rcnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        is_dm;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          delay;
      logic [3:0]  exp_mbe;
      logic [31:0] exp_if;
      logic [31:0] exp_dm;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},    omem_req, 0);
      chk({tag, "_we"},     omem_we, 0);
      chk({tag, "_be"},     omem_be, 0);
      chk({tag, "_addr"},   omem_addr, 0);
      chk({tag, "_wdata"},  omem_wdata, 0);
      chk({tag, "_ifrd"},   oif_rdata, 0);
      chk({tag, "_dmrd"},   odm_rdata, 0);
      chk({tag, "_ifv"},    oif_valid, 0);
      chk({tag, "_dmv"},    odm_valid, 0);
      chk({tag, "_ifbusy"}, oif_busy, 0);
      chk({tag, "_dmbusy"}, odm_busy, 0);
      chk({tag, "_cif"},    ocnt_if_grants, 0);
      chk({tag, "_cdm"},    ocnt_dm_grants, 0);
      chk({tag, "_cwt"},    ocnt_wait_cycles, 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   cyc;
      logic acked;
      string p;
      p = $sformatf("v%0d", idx);
      @(negedge iclk);
      mem_rdata  = v.mrdata;
      resp_delay = v.delay;
      if (v.is_dm) begin
         idm_req = 1'b1; idm_we = v.we; idm_be = v.be;
         idm_addr = v.addr; idm_wdata = v.wdata;
      end else begin
         iif_req = 1'b1; iif_addr = v.addr;
      end
      chk({p, "_req_early"}, omem_req, 0);
      acked = 1'b0;
      cyc   = 0;
      while (!acked && cyc < 20) begin
         @(negedge iclk);
         chk({p, "_mreq"},  omem_req, 1);
         chk({p, "_maddr"}, omem_addr, v.addr);
         chk({p, "_mwe"},   omem_we, v.is_dm ? v.we : 1'b0);
         chk({p, "_mbe"},   omem_be, v.exp_mbe);
         if (v.is_dm) begin
            chk({p, "_mwdata"}, omem_wdata, v.wdata);
            chk({p, "_busy"},   odm_busy, 1);
         end else begin
            chk({p, "_busy"},   oif_busy, 1);
         end
         if (imem_ack) begin
            acked = 1'b1;
            chk({p, "_latency"}, cyc, v.delay);
            if (v.is_dm) idm_req = 1'b0;
            else         iif_req = 1'b0;
         end
         cyc++;
      end
      if (!acked) begin
         chk({p, "_ack_timeout"}, 0, 1);
         iif_req = 1'b0;
         idm_req = 1'b0;
      end
      @(negedge iclk);
      chk({p, "_ifv"},    oif_valid, v.is_dm ? 1'b0 : 1'b1);
      chk({p, "_dmv"},    odm_valid, v.is_dm ? 1'b1 : 1'b0);
      chk({p, "_ifrd"},   oif_rdata, v.exp_if);
      chk({p, "_dmrd"},   odm_rdata, v.exp_dm);
      chk({p, "_reqoff"}, omem_req, 0);
      @(negedge iclk);
      chk({p, "_ifv_pulse"}, oif_valid, 0);
      chk({p, "_dmv_pulse"}, odm_valid, 0);
   endtask

   // Both ports request; logs grant order and valid-pulse cycles.
   task automatic run_mix(input int d_lim, input int f_lim, output string order,
                          output int dv, output int fv);
      int   dg, fg;
      logic prev_req, prev_ack, cur_dm;
      dg = 0; fg = 0; prev_req = 1'b0; prev_ack = 1'b0; cur_dm = 1'b0;
      order = ""; dv = -1; fv = -1;
      for (int c = 0; c < 80; c++) begin
         @(negedge iclk);
         if (odm_valid && dv < 0) dv = c;
         if (oif_valid && fv < 0) fv = c;
         if (omem_req && (!prev_req || prev_ack)) begin
            cur_dm = (omem_addr >= 32'h1000);
            order  = {order, cur_dm ? "D" : "F"};
            if (cur_dm) dg++;
            else        fg++;
         end
         mem_rdata = cur_dm ? 32'hAAAA5555 : 32'h00500093;
         if (omem_req && imem_ack) begin
            if (cur_dm && dg == d_lim)  idm_req = 1'b0;
            if (!cur_dm && fg == f_lim) iif_req = 1'b0;
         end
         prev_req = omem_req;
         prev_ack = imem_ack;
         if (!iif_req && !idm_req && !omem_req && dv >= 0 && fv >= 0) break;
      end
      iif_req = 1'b0;
      idm_req = 1'b0;
   endtask

   task automatic chk_order(input string tag, input string got, input string want);
      logic [7:0] g;
      chk({tag, "_len"}, got.len(), want.len());
      for (int i = 0; i < want.len(); i++) begin
         g = (i < got.len()) ? got[i] : 8'h00;
         chk($sformatf("%s_grant%0d", tag, i), g, want[i]);
      end
   endtask

   initial begin
      string order;
      string want;
      int    dv, fv;

      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0050_0093, 1, 4'hF,
                  32'h0050_0093, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 32'h1234_5678, 0, 4'hF,
                  32'h0050_0093, 32'h1234_5678};
      vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 5, 4'h3,
                  32'h0050_0093, 32'h1234_5678};
      vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 32'h00A0_0113, 2, 4'hF,
                  32'h00A0_0113, 32'h1234_5678};
      vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_2008, 32'h0, 32'hCAFE_F00D, 3, 4'hF,
                  32'h00A0_0113, 32'hCAFE_F00D};
      vecs[5] = '{1'b1, 1'b1, 4'hC, 32'h0000_200C, 32'h1122_3344, 32'h5555_5555, 0, 4'hC,
                  32'h00A0_0113, 32'hCAFE_F00D};

      irst_n = 1'b0;
      iif_req = 1'b0; iif_addr = '0;
      idm_req = 1'b0; idm_we = 1'b0; idm_be = '0; idm_addr = '0; idm_wdata = '0;
      mem_rdata = '0;
      repeat (2) @(negedge iclk);
      chk_all_zero("rst");
      irst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Reset while a data read is outstanding, then a stale ack.
      @(negedge iclk);
      resp_delay = 10;
      idm_req = 1'b1; idm_we = 1'b0; idm_be = 4'hF; idm_addr = 32'h2010;
      repeat (3) @(negedge iclk);
      chk("mid_req_active", omem_req, 1);
      irst_n = 1'b0;
      idm_req = 1'b0; idm_be = '0; idm_addr = '0;
      #1;
      chk_all_zero("midrst");
      @(negedge iclk);
      irst_n    = 1'b1;
      stale_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge iclk);
      stale_ack = 1'b0;
      chk("stale_req",  omem_req, 0);
      chk("stale_ifv",  oif_valid, 0);
      chk("stale_dmv",  odm_valid, 0);
      chk("stale_dmrd", odm_rdata, 0);
      @(negedge iclk);
      chk("stale_ifv2", oif_valid, 0);
      chk("stale_dmv2", odm_valid, 0);

      // Simultaneous requests, 3-cycle ack (ack in third omem_req cycle).
      @(negedge iclk);
      resp_delay = 2;
      iif_req = 1'b1; iif_addr = 32'h100;
      idm_req = 1'b1; idm_we = 1'b0; idm_be = 4'hF; idm_addr = 32'h2000;
      run_mix(1, 1, order, dv, fv);
      want = "DF";
      chk_order("sim", order, want);
      chk("sim_dv_seen", dv >= 0, 1);
      chk("sim_dm_first", fv > dv, 1);
      chk("sim_dmrd", odm_rdata, 32'hAAAA5555);
      chk("sim_ifrd", oif_rdata, 32'h00500093);
`ifdef MEM_ARB_PERF_EN
      chk("perf_if",   ocnt_if_grants, 1);
      chk("perf_dm",   ocnt_dm_grants, 1);
      chk("perf_wait", ocnt_wait_cycles, 4);
`else
      chk("perf_if",   ocnt_if_grants, 0);
      chk("perf_dm",   ocnt_dm_grants, 0);
      chk("perf_wait", ocnt_wait_cycles, 0);
`endif

      // Starvation: fetch held, six back-to-back data writes.
      @(negedge iclk);
      resp_delay = 0;
      iif_req = 1'b1; iif_addr = 32'h100;
      idm_req = 1'b1; idm_we = 1'b1; idm_be = 4'hF; idm_addr = 32'h3000;
      idm_wdata = 32'h0BAD_C0DE;
      run_mix(6, 2, order, dv, fv);
      want = "DDDDFDDF";
      chk_order("starve", order, want);
      chk("starve_dmrd_hold", odm_rdata, 32'hAAAA5555);
      chk("starve_ifrd", oif_rdata, 32'h00500093);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
